// File: rtl/inc16.sv
// 16-bit incrementer: combinational ripple chain of half adders built from gate primitives,
// plus an enable-gated registered copy of the result with a valid flag.
module inc16 (
    input  logic [15:0] in,
    output logic [15:0] out,
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        carry,
    output logic [15:0] out_r,
    output logic        carry_r,
    output logic        valid_r
);

    // c[i] is the carry into stage i; c[0] = 1 supplies the "+1".
    logic [16:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < 16; i++) begin : g_stage
        xor u_sum   (out[i],   in[i], c[i]);
        and u_carry (c[i + 1], in[i], c[i]);
    end

    assign carry = c[16];

    logic [15:0] out_q;
    logic        carry_q;
    logic        valid_q;

    // Reset takes priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 16'h0000;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            out_q   <= out;
            carry_q <= carry;
            valid_q <= 1'b1;
        end
    end

    assign out_r   = out_q;
    assign carry_r = carry_q;
    assign valid_r = valid_q;

endmodule

// File: tb/tb_inc16.sv
// Directed bench for inc16: a table of combinational increments, then hand-written
// sequences for reset, enable hold, capture latency and reset-over-enable.
module tb_inc16;

    logic [15:0] in;
    logic [15:0] out;
    logic        clk;
    logic        rst;
    logic        en;
    logic        carry;
    logic [15:0] out_r;
    logic        carry_r;
    logic        valid_r;

    int tests;
    int fails;

    inc16 u_dut (
        .in      (in),
        .out     (out),
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .carry   (carry),
        .out_r   (out_r),
        .carry_r (carry_r),
        .valid_r (valid_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vin;
        logic [15:0] exp_out;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        en    = 1'b0;
        in    = 16'h0000;

        vecs[0] = '{16'h0000, 16'h0001, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1};
        vecs[2] = '{16'h0005, 16'h0006, 1'b0};
        vecs[3] = '{16'hFFFB, 16'hFFFC, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h8000, 1'b0};
        vecs[5] = '{16'h00FF, 16'h0100, 1'b0};
        vecs[6] = '{16'h8000, 16'h8001, 1'b0};
        vecs[7] = '{16'hFFFE, 16'hFFFF, 1'b0};
        vecs[8] = '{16'hAAAA, 16'hAAAB, 1'b0};
        vecs[9] = '{16'h5555, 16'h5556, 1'b0};

        // Combinational path: one time unit, no clock edge needed.
        for (int i = 0; i < 10; i++) begin
            in = vecs[i].vin;
            #1;
            check($sformatf("comb_out[%0d]", i), out, vecs[i].exp_out);
            check($sformatf("comb_carry[%0d]", i), {15'd0, carry}, {15'd0, vecs[i].exp_carry});
        end

        // Reset state.
        rst = 1'b1; en = 1'b0;
        tick();
        check("rst_out_r", out_r, 16'h0000);
        check("rst_carry_r", {15'd0, carry_r}, 16'h0000);
        check("rst_valid_r", {15'd0, valid_r}, 16'h0000);

        // First capture.
        rst = 1'b0; en = 1'b1; in = 16'h7FFF;
        tick();
        check("cap_out_r", out_r, 16'h8000);
        check("cap_carry_r", {15'd0, carry_r}, 16'h0000);
        check("cap_valid_r", {15'd0, valid_r}, 16'h0001);

        // Enable low: registers hold while the combinational path follows in.
        en = 1'b0; in = 16'h1234;
        #1;
        check("hold_comb_out", out, 16'h1235);
        tick();
        check("hold_out_r", out_r, 16'h8000);
        check("hold_valid_r", {15'd0, valid_r}, 16'h0001);

        // Capture of the wrap-around case.
        en = 1'b1; in = 16'hFFFF;
        tick();
        check("wrap_out_r", out_r, 16'h0000);
        check("wrap_carry_r", {15'd0, carry_r}, 16'h0001);

        // Reset wins over enable; combinational outputs are untouched.
        rst = 1'b1; en = 1'b1; in = 16'hFFFF;
        tick();
        check("rst_en_out_r", out_r, 16'h0000);
        check("rst_en_carry_r", {15'd0, carry_r}, 16'h0000);
        check("rst_en_valid_r", {15'd0, valid_r}, 16'h0000);
        check("rst_en_comb_out", out, 16'h0000);
        check("rst_en_comb_carry", {15'd0, carry}, 16'h0001);

        // After reset, no capture until en is high.
        rst = 1'b0; en = 1'b0; in = 16'h0042;
        tick();
        check("post_rst_idle_valid_r", {15'd0, valid_r}, 16'h0000);
        check("post_rst_idle_out_r", out_r, 16'h0000);
        en = 1'b1;
        tick();
        check("resume_out_r", out_r, 16'h0043);
        check("resume_valid_r", {15'd0, valid_r}, 16'h0001);

        // One-cycle latency: new operand not visible before the edge.
        in = 16'h0100;
        #1;
        check("latency_before_edge", out_r, 16'h0043);
        tick();
        check("latency_after_edge", out_r, 16'h0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inc16.md
INC16 -- requirements
Module: inc16

Interface
REQ-001 The module SHALL have no parameters; the data width SHALL be fixed at 16 bits.
REQ-002 clk  input  1  single clock; all registered state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in  input  16  unsigned operand.
REQ-005 en  input  1  capture enable for the registered outputs.
REQ-006 out  output  16  combinational result, in + 1 modulo 2^16.
REQ-007 carry  output  1  combinational carry-out of the increment.
REQ-008 out_r  output  16  registered copy of out.
REQ-009 carry_r  output  1  registered copy of carry.
REQ-010 valid_r  output  1  high when out_r/carry_r hold a captured result.
REQ-011 Port order on instantiation SHALL be in, out first, so positional instantiation inc16(in, out) connects operand and result; clk, rst, en, carry, out_r, carry_r and valid_r follow.

Function
REQ-012 out SHALL equal (in + 1) mod 65536 at all times, purely combinationally, with no clock edge required.
REQ-013 out SHALL settle within the same simulation time step after in changes; no latches, no delays.
REQ-014 carry SHALL be 1 exactly when in = 16'hFFFF, else 0.
REQ-015 Wrap-around: in = 16'hFFFF SHALL give out = 16'h0000 and carry = 1.
REQ-016 The adder SHALL be a 16-stage ripple chain of half adders: stage i sum = in[i] XOR c[i], c[i+1] = in[i] AND c[i], c[0] = 1, carry = c[16].
REQ-017 Half adders SHALL be built structurally from gate primitives; no behavioural "+" operator.
REQ-018 out and carry SHALL NOT depend on clk, rst or en.
REQ-019 On a rising clk edge with rst = 0 and en = 1: out_r <= out, carry_r <= carry, valid_r <= 1.
REQ-020 On a rising clk edge with rst = 0 and en = 0: out_r, carry_r and valid_r SHALL hold their values.
REQ-021 Registered-path latency SHALL be exactly one clock cycle from the edge sampling in.
REQ-022 X/Z on in SHALL NOT be masked; the output propagates it.

Reset
REQ-023 On a rising clk edge with rst = 1: out_r <= 16'h0000, carry_r <= 0, valid_r <= 0, regardless of en.
REQ-024 If rst and en are both 1 on the same edge, rst SHALL win.
REQ-025 Reset SHALL NOT affect the combinational out and carry.
REQ-026 Reset asserted mid-stream SHALL clear the registers on that edge; capture SHALL resume on the first edge with rst = 0 and en = 1.

Verification
REQ-027 Set in = 16'h0000 and wait 1 time unit with no clock -> out = 16'h0001, carry = 0.
REQ-028 Set in = 16'hFFFF -> out = 16'h0000, carry = 1.
REQ-029 Set in = 16'h0005 -> out = 16'h0006; set in = 16'hFFFB -> out = 16'hFFFC, carry = 0.
REQ-030 Run 1 edge with rst = 1, then 1 edge with rst = 0, en = 1, in = 16'h7FFF -> out_r = 16'h8000, carry_r = 0, valid_r = 1.
REQ-031 Run an edge with en = 0 and in changed to 16'h1234 -> out_r stays 16'h8000.
REQ-032 Run an edge with rst = 1, en = 1, in = 16'hFFFF -> out_r = 0, carry_r = 0, valid_r = 0, while out = 16'h0000 and carry = 1.
